// File: rtl/hub75_rx_if.sv
// Pixel write stream from hub75_rx to a framebuffer sink.
// The master drives one pixel per valid/ready transfer.
interface hub75_rx_if #(
  parameter int unsigned X_BITS    = 7,
  parameter int unsigned ADDR_BITS = 5
) ();
  logic                 valid;
  logic                 ready;
  logic [X_BITS-1:0]    x;
  logic [ADDR_BITS-1:0] y;
  logic [2:0]           rgb0;
  logic [2:0]           rgb1;

  modport master (output valid, x, y, rgb0, rgb1, input ready);
  modport slave  (input valid, x, y, rgb0, rgb1, output ready);
endinterface

// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 panel receiver. Synchronises the scanner's SCLK/LATCH/BLANK/ADDR/RGB lines,
// shifts each row into one half of a ping-pong line buffer and, on latch, streams the committed
// row out as (x, row, rgb0, rgb1) pixel writes while the next row fills the other half.
// Optional feature: define HUB75_RX_ONTIME_EN to measure display-on time per row (row_ontime).
module hub75_rx #(
  parameter int unsigned WIDTH       = 128,
  parameter int unsigned X_BITS      = 7,
  parameter int unsigned ADDR_BITS   = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ONTIME_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hub_sclk,
  input  logic                   hub_latch,
  input  logic                   hub_blank,
  input  logic [ADDR_BITS-1:0]   hub_addry,
  input  logic [2:0]             hub_rgb0,
  input  logic [2:0]             hub_rgb1,
  hub75_rx_if.master             px,
  output logic [X_BITS:0]        col_count,
  output logic                   frame_start,
  output logic                   overrun,
  output logic [ONTIME_BITS-1:0] row_ontime
);
  localparam int unsigned SyncW = 3 + ADDR_BITS + 6;
  localparam int unsigned AW    = X_BITS + 1;
  localparam logic [AW-1:0] WidthC = AW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StFetch, StStream} state_e;

  logic [SyncW-1:0]     sync_q [SYNC_STAGES];
  logic                 sclk_s, latch_s, blank_s;
  logic [ADDR_BITS-1:0] addry_s;
  logic [5:0]           pix_s;
  logic                 sclk_prev_q, latch_prev_q;
  logic                 sclk_rise, latch_rise, shift_en;

  logic [5:0]           mem_q [2**AW];
  logic                 fill_bank_q;
  logic [AW-1:0]        wcol_q, len_q, col_count_q;
  logic [X_BITS-1:0]    idx_q;
  logic [ADDR_BITS-1:0] y_q;
  logic [2:0]           rgb0_q, rgb1_q;
  logic                 overrun_q, frame_start_q;

  state_e state_q, state_d;
  logic   commit, drop, last_beat, advance;

  // Synchroniser chain for all panel inputs plus one edge-detect flop on sclk/latch
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sclk_prev_q  <= 1'b0;
      latch_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {hub_sclk, hub_latch, hub_blank, hub_addry, hub_rgb1, hub_rgb0};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sclk_prev_q  <= sclk_s;
      latch_prev_q <= latch_s;
    end
  end

  assign {sclk_s, latch_s, blank_s, addry_s, pix_s} = sync_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign latch_rise = latch_s & ~latch_prev_q;
  // Columns beyond WIDTH are dropped; wcol parks at WIDTH
  assign shift_en   = sclk_rise & ~latch_s & (wcol_q < WidthC);

  // Fill-buffer write, one entry per accepted shift edge; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && shift_en) mem_q[{fill_bank_q, wcol_q[X_BITS-1:0]}] <= pix_s;
  end

  assign last_beat = ({1'b0, idx_q} + AW'(1)) == len_q;

  // Stream FSM next-state and handshake decode
  always_comb begin
    state_d  = state_q;
    commit   = 1'b0;
    drop     = 1'b0;
    advance  = 1'b0;
    px.valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (latch_rise) begin
          commit = 1'b1;
          if (wcol_q != '0) state_d = StFetch;
        end
      end
      StFetch: begin
        drop    = latch_rise;
        state_d = StStream;
      end
      StStream: begin
        px.valid = 1'b1;
        drop     = latch_rise;
        if (px.ready) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            advance = 1'b1;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Row commit, write pointer, stream registers and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      fill_bank_q   <= 1'b0;
      wcol_q        <= '0;
      len_q         <= '0;
      col_count_q   <= '0;
      idx_q         <= '0;
      y_q           <= '0;
      rgb0_q        <= '0;
      rgb1_q        <= '0;
      overrun_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_start_q <= commit && (addry_s == '0);
      if (commit) begin
        fill_bank_q <= ~fill_bank_q;
        y_q         <= addry_s;
        len_q       <= wcol_q;
        col_count_q <= wcol_q;
        idx_q       <= '0;
      end
      if (drop) overrun_q <= 1'b1;
      if (latch_rise)    wcol_q <= '0;
      else if (shift_en) wcol_q <= wcol_q + AW'(1);
      // Read side is the bank not being filled
      if (state_q == StFetch) begin
        {rgb1_q, rgb0_q} <= mem_q[{~fill_bank_q, idx_q}];
      end
      if (advance) idx_q <= idx_q + X_BITS'(1);
    end
  end

  assign px.x        = idx_q;
  assign px.y        = y_q;
  assign px.rgb0     = rgb0_q;
  assign px.rgb1     = rgb1_q;
  assign col_count   = col_count_q;
  assign overrun     = overrun_q;
  assign frame_start = frame_start_q;

`ifdef HUB75_RX_ONTIME_EN
  logic [ONTIME_BITS-1:0] ontime_cnt_q, row_ontime_q;

  // Count display-on cycles between latch edges, saturating; publish on each latch edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ontime_cnt_q <= '0;
      row_ontime_q <= '0;
    end else if (latch_rise) begin
      row_ontime_q <= ontime_cnt_q;
      ontime_cnt_q <= '0;
    end else if (!blank_s && (ontime_cnt_q != '1)) begin
      ontime_cnt_q <= ontime_cnt_q + ONTIME_BITS'(1);
    end
  end

  assign row_ontime = row_ontime_q;
`else
  logic unused_blank;
  assign unused_blank = blank_s;
  assign row_ontime   = '0;
`endif
endmodule
